// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares one single-port RAM between the fetch (i_*) and load/store
//            (d_*) ports. MEM_ARB_RR_EN selects round-robin, else fixed d > i.
// Revision : 1.0  initial release
// ============================================================================
module mem_arbiter #(
    parameter int MEM_BYTES = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    output logic        i_err,
    input  logic        d_req,
    input  logic [2:0]  d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic [2:0]  mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        cmd_port_q, cmd_port_d;
    logic [31:0] cmd_addr_q, cmd_addr_d;
    logic [2:0]  cmd_we_q, cmd_we_d;
    logic [31:0] cmd_wdata_q, cmd_wdata_d;
    logic        cmd_err_q, cmd_err_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic        i_err_q, i_err_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        d_err_q, d_err_d;

    logic        pick_d;
    logic        pick_i;
    logic        grant_ok;
    logic        any_gnt;
    logic [2:0]  we_norm;
    logic [31:0] acc_addr;
    logic [2:0]  acc_size;
    logic [32:0] acc_end;
    logic        acc_err;
    logic [31:0] rsp_data;

`ifdef MEM_ARB_RR_EN
    // Remembers which port won last; reset value favours d on the first tie.
    logic last_d_q, last_d_d;

    always_comb begin
        last_d_d = last_d_q;
        if (any_gnt) begin
            last_d_d = d_gnt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_d_q <= 1'b0;
        end else begin
            last_d_q <= last_d_d;
        end
    end

    assign pick_d = d_req & (~i_req | ~last_d_q);
`else
    assign pick_d = d_req;
`endif

    assign pick_i   = i_req & ~pick_d;
    assign grant_ok = rst_n & (state_q != ST_ACCESS);
    assign i_gnt    = grant_ok & pick_i;
    assign d_gnt    = grant_ok & pick_d;
    assign any_gnt  = i_gnt | d_gnt;

    always_comb begin
        we_norm = 3'b000;
        if (d_we[0]) begin
            we_norm = 3'b001;
        end else if (d_we[1]) begin
            we_norm = 3'b010;
        end else if (d_we[2]) begin
            we_norm = 3'b100;
        end

        acc_addr = pick_d ? d_addr : i_addr;
        acc_size = 3'd4;
        if (pick_d && we_norm[1]) begin
            acc_size = 3'd2;
        end else if (pick_d && we_norm[2]) begin
            acc_size = 3'd1;
        end

        // One past the last byte touched; widened so addresses near 2^32 cannot wrap.
        acc_end = {1'b0, acc_addr} + {30'd0, acc_size};
        acc_err = (acc_end > 33'(MEM_BYTES))
                | ((acc_size == 3'd4) & (acc_addr[1:0] != 2'b00))
                | ((acc_size == 3'd2) & acc_addr[0]);
    end

    assign rsp_data = (cmd_err_q || (cmd_we_q != 3'b000)) ? 32'd0 : mem_rdata;

    always_comb begin
        state_d     = state_q;
        cmd_port_d  = cmd_port_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_we_d    = cmd_we_q;
        cmd_wdata_d = cmd_wdata_q;
        cmd_err_d   = cmd_err_q;
        i_rdata_d   = i_rdata_q;
        i_err_d     = i_err_q;
        d_rdata_d   = d_rdata_q;
        d_err_d     = d_err_q;

        case (state_q)
            ST_IDLE:   state_d = any_gnt ? ST_ACCESS : ST_IDLE;
            ST_ACCESS: state_d = ST_RESP;
            ST_RESP:   state_d = any_gnt ? ST_ACCESS : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        if (any_gnt) begin
            cmd_port_d  = d_gnt;
            cmd_addr_d  = acc_addr;
            cmd_we_d    = d_gnt ? we_norm : 3'b000;
            cmd_wdata_d = d_gnt ? d_wdata : 32'd0;
            cmd_err_d   = acc_err;
        end

        if (state_q == ST_ACCESS) begin
            if (cmd_port_q) begin
                d_rdata_d = rsp_data;
                d_err_d   = cmd_err_q;
            end else begin
                i_rdata_d = rsp_data;
                i_err_d   = cmd_err_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cmd_port_q  <= 1'b0;
            cmd_addr_q  <= 32'd0;
            cmd_we_q    <= 3'b000;
            cmd_wdata_q <= 32'd0;
            cmd_err_q   <= 1'b0;
            i_rdata_q   <= 32'd0;
            i_err_q     <= 1'b0;
            d_rdata_q   <= 32'd0;
            d_err_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_port_q  <= cmd_port_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_we_q    <= cmd_we_d;
            cmd_wdata_q <= cmd_wdata_d;
            cmd_err_q   <= cmd_err_d;
            i_rdata_q   <= i_rdata_d;
            i_err_q     <= i_err_d;
            d_rdata_q   <= d_rdata_d;
            d_err_q     <= d_err_d;
        end
    end

    // Erroring commands still occupy the ACCESS slot but never write.
    assign mem_we    = ((state_q == ST_ACCESS) && !cmd_err_q) ? cmd_we_q : 3'b000;
    assign mem_addr  = cmd_addr_q;
    assign mem_wdata = cmd_wdata_q;

    assign i_rvalid  = (state_q == ST_RESP) & ~cmd_port_q;
    assign d_rvalid  = (state_q == ST_RESP) & cmd_port_q;
    assign i_rdata   = i_rdata_q;
    assign i_err     = i_err_q;
    assign d_rdata   = d_rdata_q;
    assign d_err     = d_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Directed scoreboard bench for mem_arbiter with a behavioural RAM.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int MEM_BYTES = 4096;

    logic        clk;
    logic        rst_n;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        i_err;
    logic        d_req;
    logic [2:0]  d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_err;
    logic [2:0]  mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    mem_arbiter #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_gnt    (i_gnt),
        .i_rvalid (i_rvalid),
        .i_rdata  (i_rdata),
        .i_err    (i_err),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .d_err    (d_err),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural big-endian RAM with combinational read.
    logic [7:0]  mem     [MEM_BYTES];
    logic [7:0]  ref_mem [MEM_BYTES];
    logic [11:0] ra;
    assign ra = mem_addr[11:0];
    assign mem_rdata = {mem[ra], mem[ra + 12'd1], mem[ra + 12'd2], mem[ra + 12'd3]};

    always @(posedge clk) begin
        if (mem_we[0]) begin
            mem[ra]         <= mem_wdata[31:24];
            mem[ra + 12'd1] <= mem_wdata[23:16];
            mem[ra + 12'd2] <= mem_wdata[15:8];
            mem[ra + 12'd3] <= mem_wdata[7:0];
        end else if (mem_we[1]) begin
            mem[ra]         <= mem_wdata[15:8];
            mem[ra + 12'd1] <= mem_wdata[7:0];
        end else if (mem_we[2]) begin
            mem[ra]         <= mem_wdata[7:0];
        end
    end

    typedef struct {
        logic        pd;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          we_cycles = 0;
    logic [2:0]  last_we = 3'b000;
    logic [31:0] last_we_addr = 32'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: returns the response and applies stores to ref_mem.
    function automatic void model(input logic pd, input logic [2:0] we, input logic [31:0] addr,
                                  input logic [31:0] wd, output exp_t e);
        int         size;
        logic [2:0] w;
        longint     a;
        int         ai;
        w = pd ? we : 3'b000;
        if (w[0])      size = 4;
        else if (w[1]) size = 2;
        else if (w[2]) size = 1;
        else           size = 4;
        a = longint'({32'd0, addr});
        e.pd    = pd;
        e.rdata = 32'd0;
        e.err   = (a + size > MEM_BYTES) || (size == 4 && addr[1:0] != 2'b00) || (size == 2 && addr[0]);
        if (!e.err) begin
            ai = int'(addr[11:0]);
            if (w == 3'b000) begin
                e.rdata = {ref_mem[ai], ref_mem[ai+1], ref_mem[ai+2], ref_mem[ai+3]};
            end else if (w[0]) begin
                ref_mem[ai]   = wd[31:24];
                ref_mem[ai+1] = wd[23:16];
                ref_mem[ai+2] = wd[15:8];
                ref_mem[ai+3] = wd[7:0];
            end else if (w[1]) begin
                ref_mem[ai]   = wd[15:8];
                ref_mem[ai+1] = wd[7:0];
            end else begin
                ref_mem[ai]   = wd[7:0];
            end
        end
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (i_rvalid || d_rvalid) begin
            chk("rvalid_onehot", {31'd0, i_rvalid & d_rvalid}, 32'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_rvalid", {30'd0, i_rvalid, d_rvalid}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("resp_port", {31'd0, d_rvalid}, {31'd0, e.pd});
                chk("resp_rdata", d_rvalid ? d_rdata : i_rdata, e.rdata);
                chk("resp_err", {31'd0, d_rvalid ? d_err : i_err}, {31'd0, e.err});
            end
        end
        if (mem_we != 3'b000) begin
            we_cycles++;
            last_we      = mem_we;
            last_we_addr = mem_addr;
        end
    end

    task automatic do_op(input logic pd, input logic [2:0] we, input logic [31:0] addr, input logic [31:0] wd);
        exp_t e;
        logic got;
        model(pd, we, addr, wd, e);
        exp_q.push_back(e);
        @(posedge clk); #1;
        if (pd) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wd;
        end else begin
            i_req = 1'b1; i_addr = addr;
        end
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (pd ? d_gnt : i_gnt) got = 1'b1;
        end
        chk("gnt_seen", {31'd0, got}, 32'd1);
        @(posedge clk); #1;
        i_req = 1'b0;
        d_req = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk(tag, exp_q.size(), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk(tag, {i_gnt, d_gnt, i_rvalid, d_rvalid, i_err, d_err, mem_we}, 32'd0);
        chk(tag, i_rdata | d_rdata | mem_addr | mem_wdata, 32'd0);
    endtask

    initial begin
        logic [31:0] daddr[3];
        logic [31:0] iaddr[3];
        logic        order[6];
        exp_t        e;
        int          di, ii, k, bad;
        logic        gi, gd;

        for (int a = 0; a < MEM_BYTES; a++) begin
            mem[a]     = 8'(a * 7 + 3);
            ref_mem[a] = 8'(a * 7 + 3);
        end
        mem[16] = 8'hDE; mem[17] = 8'hAD; mem[18] = 8'hBE; mem[19] = 8'hEF;
        ref_mem[16] = 8'hDE; ref_mem[17] = 8'hAD; ref_mem[18] = 8'hBE; ref_mem[19] = 8'hEF;

        rst_n = 1'b0; i_req = 1'b0; i_addr = 32'd0;
        d_req = 1'b0; d_we = 3'b000; d_addr = 32'd0; d_wdata = 32'd0;
        #3;
        chk_outputs_zero("reset_outputs");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Simultaneous requests, three per port, straight out of reset.
        daddr[0] = 32'h100; daddr[1] = 32'h104; daddr[2] = 32'h108;
        iaddr[0] = 32'h200; iaddr[1] = 32'h204; iaddr[2] = 32'h208;
`ifdef MEM_ARB_RR_EN
        order[0] = 1; order[1] = 0; order[2] = 1; order[3] = 0; order[4] = 1; order[5] = 0;
`else
        order[0] = 1; order[1] = 1; order[2] = 1; order[3] = 0; order[4] = 0; order[5] = 0;
`endif
        di = 0; ii = 0;
        for (int n = 0; n < 6; n++) begin
            if (order[n]) begin
                model(1'b1, 3'b000, daddr[di], 32'd0, e); di++;
            end else begin
                model(1'b0, 3'b000, iaddr[ii], 32'd0, e); ii++;
            end
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 3'b000; d_addr = daddr[0];
        i_req = 1'b1; i_addr = iaddr[0];
        di = 0; ii = 0; k = 0;
        for (int c = 0; c < 60 && k < 6; c++) begin
            @(negedge clk);
            gi = i_gnt;
            gd = d_gnt;
            if (gi || gd) begin
                chk("gnt_onehot", {31'd0, gi & gd}, 32'd0);
                chk("gnt_order", {31'd0, gd}, {31'd0, order[k]});
                k++;
            end
            @(posedge clk); #1;
            if (gd) begin
                di++;
                if (di < 3) d_addr = daddr[di]; else d_req = 1'b0;
            end
            if (gi) begin
                ii++;
                if (ii < 3) i_addr = iaddr[ii]; else i_req = 1'b0;
            end
        end
        chk("gnt_count", k, 32'd6);
        i_req = 1'b0; d_req = 1'b0;
        drain("drain_simul");

        // Fetch latency: gnt at T, RAM address at T+1, rvalid at T+2.
        model(1'b0, 3'b000, 32'h10, 32'd0, e);
        exp_q.push_back(e);
        i_req = 1'b1; i_addr = 32'h10;
        @(negedge clk);
        chk("t1_gnt", {31'd0, i_gnt}, 32'd1);
        @(posedge clk); #1;
        i_req = 1'b0;
        @(negedge clk);
        chk("t1_mem_addr", mem_addr, 32'h10);
        chk("t1_no_rvalid_early", {31'd0, i_rvalid}, 32'd0);
        @(negedge clk);
        chk("t1_rvalid", {31'd0, i_rvalid}, 32'd1);
        chk("t1_rdata", i_rdata, 32'hDEADBEEF);
        drain("drain_t1");

        // Word store, then load back.
        we_cycles = 0;
        do_op(1'b1, 3'b001, 32'h20, 32'h11223344);
        drain("drain_t2_store");
        chk("t2_we_cycles", we_cycles, 32'd1);
        chk("t2_we_value", {29'd0, last_we}, 32'd1);
        chk("t2_we_addr", last_we_addr, 32'h20);
        do_op(1'b1, 3'b000, 32'h20, 32'd0);
        drain("drain_t2_load");

        // Byte store into the middle of that word; d_we=110 normalises to half.
        we_cycles = 0;
        do_op(1'b1, 3'b100, 32'h21, 32'h000000AA);
        drain("drain_t3_byte");
        chk("t3_we_value", {29'd0, last_we}, 32'd4);
        do_op(1'b1, 3'b000, 32'h20, 32'd0);
        drain("drain_t3_load");
        chk("t3_ram_word", {mem[32], mem[33], mem[34], mem[35]}, 32'h11AA3344);
        do_op(1'b1, 3'b110, 32'h24, 32'h0000BEEF);
        do_op(1'b1, 3'b000, 32'h24, 32'd0);
        drain("drain_t3_half");
        chk("t3_half_we", {29'd0, last_we}, 32'd2);

        // Boundary: legal accesses ending at the last byte.
        do_op(1'b1, 3'b010, 32'hFFE, 32'h00001234);
        do_op(1'b1, 3'b000, 32'hFFC, 32'd0);
        do_op(1'b0, 3'b000, 32'hFFC, 32'd0);
        drain("drain_boundary");

        // Error accesses: misaligned or out of range never write.
        we_cycles = 0;
        do_op(1'b1, 3'b001, 32'h22, 32'h55667788);
        do_op(1'b1, 3'b010, 32'h23, 32'h00009999);
        do_op(1'b1, 3'b001, 32'hFFD, 32'hCAFECAFE);
        do_op(1'b1, 3'b100, 32'h1000, 32'h000000EE);
        do_op(1'b1, 3'b000, 32'h22, 32'd0);
        do_op(1'b0, 3'b000, 32'h1000, 32'd0);
        do_op(1'b0, 3'b000, 32'h2, 32'd0);
        drain("drain_errors");
        chk("t5_no_writes", we_cycles, 32'd0);

        // Asynchronous reset during the ACCESS cycle of a store.
        we_cycles = 0;
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 3'b001; d_addr = 32'h40; d_wdata = 32'hCAFEF00D;
        @(negedge clk);
        chk("t6_gnt", {31'd0, d_gnt}, 32'd1);
        @(posedge clk); #1;
        d_req = 1'b0;
        chk("t6_in_access", {29'd0, mem_we}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk_outputs_zero("t6_reset_outputs");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("t6_no_write", we_cycles, 32'd0);
        chk("t6_ram_bytes", {mem[64], mem[65], mem[66], mem[67]},
            {ref_mem[64], ref_mem[65], ref_mem[66], ref_mem[67]});
        do_op(1'b1, 3'b000, 32'h40, 32'd0);
        drain("drain_t6_load");

        bad = 0;
        for (int a = 0; a < MEM_BYTES; a++) begin
            if (mem[a] !== ref_mem[a]) bad++;
        end
        chk("ram_contents", bad, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
